pic_control_registers: RTL and testbench
========================================

Name: pic_control_registers

Overview:
- Sits directly downstream of the 8259 read/write block.
- Consumes its single-cycle write strobes (ICW1, ICW2-4, OCW1-3) and the internal data bus.
- Sequences ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialization, holds all mode and mask registers, and decodes OCW2/OCW3 into command pulses for the priority resolver and in-service logic.
- Muxes IRR/ISR/IMR onto the read data path.

Parameters:
MASK_RESET_VALUE, 8'h00, value loaded into interrupt_mask on reset and on every ICW1 write

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
internal_data_bus  input  8  write data from read/write block
address_0  input  1  A0 of the current access
write_initial_command_word_1  input  1  ICW1 write strobe, one cycle
write_initial_command_word_2_4  input  1  A0=1 write strobe, one cycle
write_operation_control_word_1  input  1  OCW1 write strobe (A0=1), one cycle
write_operation_control_word_2  input  1  OCW2 write strobe, one cycle
write_operation_control_word_3  input  1  OCW3 write strobe, one cycle
read  input  1  read strobe
interrupt_request_register  input  8  IRR from request block
in_service_register  input  8  ISR from in-service block
read_data_bus  output  8  read data
init_done  output  1  high in READY state
level_or_edge_triggered  output  1  ICW1 D3 (LTIM)
single_mode  output  1  ICW1 D1 (SNGL)
interrupt_vector_address  output  5  ICW2 D7-D3
cascade_device_config  output  8  ICW3
u8086_mode  output  1  ICW4 D0
auto_eoi  output  1  ICW4 D1
buffered_master  output  1  ICW4 D2
buffered_mode  output  1  ICW4 D3
special_fully_nested  output  1  ICW4 D4
interrupt_mask  output  8  IMR
end_of_interrupt  output  1  non-specific EOI pulse
specific_eoi  output  1  specific EOI pulse
rotate_on_eoi  output  1  rotate accompanying EOI pulse
set_priority  output  1  set-priority pulse
command_level  output  3  OCW2 L2-L0, valid with pulses
auto_rotate_mode  output  1  rotate-in-AEOI flag
special_mask_mode  output  1  SMM flag
poll_command  output  1  OCW3 poll pulse
clear_priority  output  1  pulse on ICW1, resets rotation to IR7 lowest

Behaviour:
- All state updates on the rising clock edge. Strobes are sampled as single-cycle pulses.
- Reset:
  - state=WAIT_ICW2.
  - All mode outputs = 0.
  - interrupt_mask = MASK_RESET_VALUE.
  - Read select = IRR. SMM = 0. auto_rotate_mode = 0.
  - All pulse outputs = 0.
  - init_done = 0.
- FSM states: READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
- ICW1 strobe (any state, highest priority):
  - Latch LTIM, SNGL and IC4.
  - Clear interrupt_mask to MASK_RESET_VALUE.
  - Clear SMM and auto_rotate_mode; read select = IRR.
  - If IC4=0, clear all ICW4 fields.
  - Pulse clear_priority for 1 cycle. Next state = WAIT_ICW2.
- ICW2-4 strobe advances the sequence:
  - In WAIT_ICW2: latch D7-D3. Next state = WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
  - In WAIT_ICW3: latch cascade_device_config. Next state = WAIT_ICW4 if IC4=1, else READY.
  - In WAIT_ICW4: latch ICW4 bits 4:0. Next state = READY.
- OCW1 strobe:
  - Loads interrupt_mask only in READY.
  - Outside READY it is ignored; the ICW2-4 strobe takes precedence when both are asserted.
- OCW2/OCW3 strobes are ignored outside READY.
- OCW2 decode on {R,SL,EOI}=D7-D5. Pulses are 1 cycle wide, registered (asserted the cycle after the strobe). command_level=D2-D0, held until the next OCW2.
  - 001: end_of_interrupt.
  - 011: specific_eoi.
  - 101: end_of_interrupt + rotate_on_eoi.
  - 111: specific_eoi + rotate_on_eoi.
  - 110: set_priority.
  - 100: auto_rotate_mode <= 1.
  - 000: auto_rotate_mode <= 0.
  - 010: no operation.
- OCW3:
  - D6(ESMM)=1: special_mask_mode <= D5. Otherwise SMM is unchanged.
  - D1(RR)=1: read select <= D0 (1=ISR, 0=IRR). Otherwise unchanged.
  - D2(P)=1: poll_command pulses for 1 cycle (registered).
- read_data_bus (combinational):
  - address_0=1: interrupt_mask.
  - address_0=0: ISR or IRR per read select.
  - Driven regardless of the read strobe; the read/write block gates the bus.
- Simultaneous events: reset > ICW1 > ICW2-4 > OCW1/2/3. Multiple OCW strobes in one cycle are all applied independently.
- Reset mid-sequence: abandons initialization and returns to WAIT_ICW2 with reset values.
- ICW1 mid-sequence: restarts initialization.

Decomposition:
- Shared package pic_defs holds:
  - FSM state encoding.
  - OCW2 command codes (EOI_NONSPEC=3'b001, EOI_SPEC=3'b011, ROT_NONSPEC=3'b101, ROT_SPEC=3'b111, SET_PRIO=3'b110, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000).
  - ICW/OCW bit-index constants.
- One sub-module, pic_ocw2_decoder: combinational command decode plus registered pulse generation.

Test Plan:
1. Reset, ICW1=8'h13 (SNGL=1, IC4=1, edge), ICW2=8'h20, ICW4=8'h03 -> interrupt_vector_address=5'b00100, u8086_mode=1, auto_eoi=1, WAIT_ICW3 skipped, init_done=1 after 3rd strobe.
2. ICW1=8'h11 (cascade, IC4=1), ICW2=8'h08, ICW3=8'h04, ICW4=8'h01 -> cascade_device_config=8'h04, init_done=1 only after ICW4; OCW1=8'hFF issued during WAIT_ICW3 leaves interrupt_mask=8'h00.
3. In READY: OCW1=8'hA5 then read with address_0=1 -> read_data_bus=8'hA5; a later ICW1 -> interrupt_mask=8'h00 and clear_priority pulses once.
4. OCW2=8'h20 -> end_of_interrupt high exactly 1 cycle; OCW2=8'hE3 -> specific_eoi and rotate_on_eoi pulse, command_level=3'd3; OCW2=8'h80 -> auto_rotate_mode=1; OCW2=8'h00 -> auto_rotate_mode=0.
5. IRR=8'h0F, ISR=8'h80: OCW3=8'h0B, read with address_0=0 -> 8'h80; OCW3=8'h0A -> 8'h0F; OCW3=8'h68 -> special_mask_mode=1; OCW3=8'h0C -> poll_command 1-cycle pulse.
6. ICW1=8'h13, ICW2=8'h20, then ICW1 again asserted in the same cycle as reset -> all outputs at reset values; then ICW1 mid-WAIT_ICW4 -> state returns to WAIT_ICW2 and ICW4 fields cleared if IC4=0.

Source files
------------

// File: rtl/pic_control_registers_pkg.sv
// Shared definitions for the 8259 control-register slice: FSM encoding,
// OCW2 command codes and the bit positions of fields inside ICW/OCW bytes.
package pic_defs;

    typedef enum logic [1:0] {
        ST_READY     = 2'd0,
        ST_WAIT_ICW2 = 2'd1,
        ST_WAIT_ICW3 = 2'd2,
        ST_WAIT_ICW4 = 2'd3
    } pic_state_e;

    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] EOI_NONSPEC  = 3'b001;
    localparam logic [2:0] OCW2_NOP     = 3'b010;
    localparam logic [2:0] EOI_SPEC     = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_NONSPEC  = 3'b101;
    localparam logic [2:0] SET_PRIO     = 3'b110;
    localparam logic [2:0] ROT_SPEC     = 3'b111;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_POLL = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    // {R, SL, EOI} occupies the top three bits of OCW2.
    function automatic logic [2:0] ocw2_command(input logic [7:0] data);
        return data[7:5];
    endfunction

endpackage

// File: rtl/pic_ocw2_decoder.sv
// Decodes an OCW2 write into one-cycle registered command pulses, holds the
// command level and the rotate-in-automatic-EOI flag.
module pic_ocw2_decoder
    import pic_defs::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       strobe,
    input  logic [2:0] command,
    input  logic [2:0] level,
    output logic       end_of_interrupt,
    output logic       specific_eoi,
    output logic       rotate_on_eoi,
    output logic       set_priority,
    output logic [2:0] command_level,
    output logic       auto_rotate_mode
);

    logic eoi_s;
    logic seoi_s;
    logic rot_s;
    logic setp_s;
    logic aeoi_set_s;
    logic aeoi_clr_s;

    // Command decode of the current OCW2 byte.
    always_comb begin
        eoi_s      = 1'b0;
        seoi_s     = 1'b0;
        rot_s      = 1'b0;
        setp_s     = 1'b0;
        aeoi_set_s = 1'b0;
        aeoi_clr_s = 1'b0;
        if (strobe) begin
            case (command)
                EOI_NONSPEC:  eoi_s = 1'b1;
                EOI_SPEC:     seoi_s = 1'b1;
                ROT_NONSPEC:  begin eoi_s = 1'b1;  rot_s = 1'b1; end
                ROT_SPEC:     begin seoi_s = 1'b1; rot_s = 1'b1; end
                SET_PRIO:     setp_s = 1'b1;
                ROT_AEOI_SET: aeoi_set_s = 1'b1;
                ROT_AEOI_CLR: aeoi_clr_s = 1'b1;
                default:      eoi_s = 1'b0;
            endcase
        end else begin
            eoi_s = 1'b0;
        end
    end

    // Registered pulses, held level and rotate-in-AEOI flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            end_of_interrupt <= 1'b0;
            specific_eoi     <= 1'b0;
            rotate_on_eoi    <= 1'b0;
            set_priority     <= 1'b0;
            command_level    <= 3'd0;
            auto_rotate_mode <= 1'b0;
        end else begin
            end_of_interrupt <= eoi_s;
            specific_eoi     <= seoi_s;
            rotate_on_eoi    <= rot_s;
            set_priority     <= setp_s;
            if (strobe) begin
                command_level <= level;
            end
            if (clear) begin
                auto_rotate_mode <= 1'b0;
            end else if (aeoi_set_s) begin
                auto_rotate_mode <= 1'b1;
            end else if (aeoi_clr_s) begin
                auto_rotate_mode <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pic_control_registers.sv
// 8259 control registers: ICW initialization sequencer, mode/mask registers,
// OCW2/OCW3 command decode and the IRR/ISR/IMR read multiplexer.
module pic_control_registers
    import pic_defs::*;
#(
    parameter logic [7:0] MASK_RESET_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] internal_data_bus,
    input  logic       address_0,
    input  logic       write_initial_command_word_1,
    input  logic       write_initial_command_word_2_4,
    input  logic       write_operation_control_word_1,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    input  logic       read,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] in_service_register,
    output logic [7:0] read_data_bus,
    output logic       init_done,
    output logic       level_or_edge_triggered,
    output logic       single_mode,
    output logic [4:0] interrupt_vector_address,
    output logic [7:0] cascade_device_config,
    output logic       u8086_mode,
    output logic       auto_eoi,
    output logic       buffered_master,
    output logic       buffered_mode,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic       end_of_interrupt,
    output logic       specific_eoi,
    output logic       rotate_on_eoi,
    output logic       set_priority,
    output logic [2:0] command_level,
    output logic       auto_rotate_mode,
    output logic       special_mask_mode,
    output logic       poll_command,
    output logic       clear_priority
);

    pic_state_e state_r;
    pic_state_e state_next;
    logic       init_done_r;
    logic       ltim_r;
    logic       sngl_r;
    logic       ic4_r;
    logic [4:0] vector_r;
    logic [7:0] cascade_r;
    logic [4:0] icw4_r;
    logic [7:0] mask_r;
    logic       smm_r;
    logic       read_isr_r;
    logic       poll_r;
    logic       clear_priority_r;
    logic       ocw_enable_s;
    logic       unused_read_s;

    // The read/write block gates the bus, so the strobe itself is not needed.
    assign unused_read_s = read;
    assign ocw_enable_s  = (state_r == ST_READY) && !write_initial_command_word_1;

    // Initialization sequence next-state logic.
    always_comb begin
        state_next = state_r;
        if (write_initial_command_word_1) begin
            state_next = ST_WAIT_ICW2;
        end else if (write_initial_command_word_2_4) begin
            case (state_r)
                ST_WAIT_ICW2: begin
                    if (!sngl_r)    state_next = ST_WAIT_ICW3;
                    else if (ic4_r) state_next = ST_WAIT_ICW4;
                    else            state_next = ST_READY;
                end
                ST_WAIT_ICW3: state_next = ic4_r ? ST_WAIT_ICW4 : ST_READY;
                ST_WAIT_ICW4: state_next = ST_READY;
                default:      state_next = state_r;
            endcase
        end else begin
            state_next = state_r;
        end
    end

    // State register and registered init_done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_WAIT_ICW2;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_next;
            init_done_r <= (state_next == ST_READY);
        end
    end

    // Mode, mask and OCW3 registers; ICW1 overrides everything but reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ltim_r <= 1'b0; sngl_r <= 1'b0; ic4_r <= 1'b0;
            vector_r <= 5'd0; cascade_r <= 8'h00; icw4_r <= 5'd0;
            mask_r <= MASK_RESET_VALUE; smm_r <= 1'b0; read_isr_r <= 1'b0;
            poll_r <= 1'b0; clear_priority_r <= 1'b0;
        end else if (write_initial_command_word_1) begin
            ltim_r     <= internal_data_bus[ICW1_LTIM];
            sngl_r     <= internal_data_bus[ICW1_SNGL];
            ic4_r      <= internal_data_bus[ICW1_IC4];
            mask_r     <= MASK_RESET_VALUE;
            smm_r      <= 1'b0;
            read_isr_r <= 1'b0;
            poll_r     <= 1'b0;
            clear_priority_r <= 1'b1;
            if (!internal_data_bus[ICW1_IC4]) begin
                icw4_r <= 5'd0;
            end
        end else begin
            clear_priority_r <= 1'b0;
            poll_r <= ocw_enable_s && write_operation_control_word_3
                      && internal_data_bus[OCW3_POLL];
            if (write_initial_command_word_2_4 && state_r == ST_WAIT_ICW2) begin
                vector_r <= internal_data_bus[7:3];
            end
            if (write_initial_command_word_2_4 && state_r == ST_WAIT_ICW3) begin
                cascade_r <= internal_data_bus;
            end
            if (write_initial_command_word_2_4 && state_r == ST_WAIT_ICW4) begin
                icw4_r <= internal_data_bus[4:0];
            end
            if (ocw_enable_s && write_operation_control_word_1) begin
                mask_r <= internal_data_bus;
            end
            if (ocw_enable_s && write_operation_control_word_3) begin
                if (internal_data_bus[OCW3_ESMM]) smm_r <= internal_data_bus[OCW3_SMM];
                if (internal_data_bus[OCW3_RR])   read_isr_r <= internal_data_bus[OCW3_RIS];
            end
        end
    end

    pic_ocw2_decoder u_ocw2_decoder (
        .clock            (clock),
        .reset            (reset),
        .clear            (write_initial_command_word_1),
        .strobe           (ocw_enable_s && write_operation_control_word_2),
        .command          (ocw2_command(internal_data_bus)),
        .level            (internal_data_bus[2:0]),
        .end_of_interrupt (end_of_interrupt),
        .specific_eoi     (specific_eoi),
        .rotate_on_eoi    (rotate_on_eoi),
        .set_priority     (set_priority),
        .command_level    (command_level),
        .auto_rotate_mode (auto_rotate_mode)
    );

    assign read_data_bus = address_0  ? mask_r :
                           read_isr_r ? in_service_register : interrupt_request_register;

    assign init_done                = init_done_r;
    assign level_or_edge_triggered  = ltim_r;
    assign single_mode              = sngl_r;
    assign interrupt_vector_address = vector_r;
    assign cascade_device_config    = cascade_r;
    assign u8086_mode               = icw4_r[0];
    assign auto_eoi                 = icw4_r[1];
    assign buffered_master          = icw4_r[2];
    assign buffered_mode            = icw4_r[3];
    assign special_fully_nested     = icw4_r[4];
    assign interrupt_mask           = mask_r;
    assign special_mask_mode        = smm_r;
    assign poll_command             = poll_r;
    assign clear_priority           = clear_priority_r;

endmodule

// File: tb/tb_pic_control_registers.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_pic_control_registers;

    logic       clock = 1'b0;
    logic       reset, address_0, read;
    logic       w_icw1, w_icw24, w_ocw1, w_ocw2, w_ocw3;
    logic [7:0] data_bus, irr, isr;
    logic [7:0] read_data_bus, cascade_device_config, interrupt_mask;
    logic [4:0] interrupt_vector_address;
    logic [2:0] command_level;
    logic init_done, level_or_edge_triggered, single_mode, u8086_mode, auto_eoi;
    logic buffered_master, buffered_mode, special_fully_nested;
    logic end_of_interrupt, specific_eoi, rotate_on_eoi, set_priority;
    logic auto_rotate_mode, special_mask_mode, poll_command, clear_priority;

    always #5 clock = ~clock;

    pic_control_registers dut (
        .clock(clock), .reset(reset), .internal_data_bus(data_bus), .address_0(address_0),
        .write_initial_command_word_1(w_icw1), .write_initial_command_word_2_4(w_icw24),
        .write_operation_control_word_1(w_ocw1), .write_operation_control_word_2(w_ocw2),
        .write_operation_control_word_3(w_ocw3), .read(read),
        .interrupt_request_register(irr), .in_service_register(isr),
        .read_data_bus(read_data_bus), .init_done(init_done),
        .level_or_edge_triggered(level_or_edge_triggered), .single_mode(single_mode),
        .interrupt_vector_address(interrupt_vector_address),
        .cascade_device_config(cascade_device_config), .u8086_mode(u8086_mode),
        .auto_eoi(auto_eoi), .buffered_master(buffered_master), .buffered_mode(buffered_mode),
        .special_fully_nested(special_fully_nested), .interrupt_mask(interrupt_mask),
        .end_of_interrupt(end_of_interrupt), .specific_eoi(specific_eoi),
        .rotate_on_eoi(rotate_on_eoi), .set_priority(set_priority),
        .command_level(command_level), .auto_rotate_mode(auto_rotate_mode),
        .special_mask_mode(special_mask_mode), .poll_command(poll_command),
        .clear_priority(clear_priority)
    );

    typedef struct packed {
        logic [7:0] rd;
        logic       done, ltim, sngl;
        logic [4:0] vec;
        logic [7:0] cas;
        logic [4:0] icw4;
        logic [7:0] mask;
        logic       eoi, seoi, rot, setp;
        logic [2:0] lvl;
        logic       arot, smm, poll, clrp;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;

    // Reference model: pending ICW steps are kept as a list of what is still owed.
    int         pend[$];
    logic       m_ltim, m_sngl, m_ic4, m_smm, m_arot, m_risr;
    logic [4:0] m_vec, m_icw4;
    logic [7:0] m_cas, m_mask;
    logic [2:0] m_lvl;
    logic [7:0] cur_irr = 8'h00, cur_isr = 8'h00;
    logic       cur_a0  = 1'b0;

    task automatic model_step();
        obs_t e;
        bit   rdy;
        int   step;
        e = '0;
        if (reset) begin
            m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_vec = 0; m_cas = 0; m_icw4 = 0;
            m_mask = 8'h00; m_smm = 0; m_arot = 0; m_risr = 0; m_lvl = 0;
            pend.delete(); pend.push_back(2); pend.push_back(3);
        end else if (w_icw1) begin
            m_ltim = data_bus[3]; m_sngl = data_bus[1]; m_ic4 = data_bus[0];
            m_mask = 8'h00; m_smm = 0; m_arot = 0; m_risr = 0;
            if (!m_ic4) m_icw4 = 0;
            e.clrp = 1'b1;
            pend.delete(); pend.push_back(2);
            if (!m_sngl) pend.push_back(3);
            if (m_ic4)   pend.push_back(4);
        end else begin
            rdy = (pend.size() == 0);
            if (w_icw24 && !rdy) begin
                step = pend.pop_front();
                if (step == 2)      m_vec  = data_bus[7:3];
                else if (step == 3) m_cas  = data_bus;
                else                m_icw4 = data_bus[4:0];
            end
            if (rdy && w_ocw1) m_mask = data_bus;
            if (rdy && w_ocw2) begin
                m_lvl = data_bus[2:0];
                case (data_bus[7:5])
                    3'd1: e.eoi = 1'b1;
                    3'd3: e.seoi = 1'b1;
                    3'd5: begin e.eoi = 1'b1; e.rot = 1'b1; end
                    3'd7: begin e.seoi = 1'b1; e.rot = 1'b1; end
                    3'd6: e.setp = 1'b1;
                    3'd4: m_arot = 1'b1;
                    3'd0: m_arot = 1'b0;
                    default: ;
                endcase
            end
            if (rdy && w_ocw3) begin
                if (data_bus[6]) m_smm  = data_bus[5];
                if (data_bus[1]) m_risr = data_bus[0];
                e.poll = data_bus[2];
            end
        end
        e.rd   = cur_a0 ? m_mask : (m_risr ? cur_isr : cur_irr);
        e.done = (pend.size() == 0);
        e.ltim = m_ltim; e.sngl = m_sngl; e.vec = m_vec; e.cas = m_cas; e.icw4 = m_icw4;
        e.mask = m_mask; e.lvl = m_lvl; e.arot = m_arot; e.smm = m_smm;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic i1, input logic i24, input logic o1,
                       input logic o2, input logic o3, input logic [7:0] d);
        @(negedge clock);
        #1;
        reset = r; w_icw1 = i1; w_icw24 = i24; w_ocw1 = o1; w_ocw2 = o2; w_ocw3 = o3;
        data_bus = d; address_0 = cur_a0; irr = cur_irr; isr = cur_isr;
        read = $urandom_range(0, 1) == 1;
        model_step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
    endtask

    // Monitor: every negedge with a pending expectation compares all outputs.
    initial begin
        obs_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cycle++;
                chk("read_data_bus", 32'(read_data_bus), 32'(e.rd));
                chk("init_done", 32'(init_done), 32'(e.done));
                chk("modes_icw1", 32'({level_or_edge_triggered, single_mode}), 32'({e.ltim, e.sngl}));
                chk("vector", 32'(interrupt_vector_address), 32'(e.vec));
                chk("cascade", 32'(cascade_device_config), 32'(e.cas));
                chk("icw4_fields", 32'({special_fully_nested, buffered_mode, buffered_master,
                                        auto_eoi, u8086_mode}), 32'(e.icw4));
                chk("interrupt_mask", 32'(interrupt_mask), 32'(e.mask));
                chk("ocw2_pulses", 32'({end_of_interrupt, specific_eoi, rotate_on_eoi, set_priority}),
                    32'({e.eoi, e.seoi, e.rot, e.setp}));
                chk("command_level", 32'(command_level), 32'(e.lvl));
                chk("auto_rotate_mode", 32'(auto_rotate_mode), 32'(e.arot));
                chk("special_mask_mode", 32'(special_mask_mode), 32'(e.smm));
                chk("poll_command", 32'(poll_command), 32'(e.poll));
                chk("clear_priority", 32'(clear_priority), 32'(e.clrp));
            end
        end
    end

    task automatic op(input int kind, input logic [7:0] d);
        cyc(1'b0, kind == 1, kind == 2, kind == 3, kind == 4, kind == 5, d);
    endtask

    initial begin
        int k;
        reset = 1'b1; w_icw1 = 0; w_icw24 = 0; w_ocw1 = 0; w_ocw2 = 0; w_ocw3 = 0;
        data_bus = 8'h00; address_0 = 0; read = 0; irr = 8'h00; isr = 8'h00;
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        op(0, 8'h00);
        // Single, ICW4 required: ICW3 is skipped.
        op(1, 8'h13); op(2, 8'h20); op(2, 8'h03); op(0, 8'h00);
        // Cascade: OCW1 during WAIT_ICW3 is ignored.
        op(1, 8'h11); op(2, 8'h08); op(3, 8'hFF); op(2, 8'h04); op(2, 8'h01); op(0, 8'h00);
        cur_a0 = 1'b1;
        op(3, 8'hA5); op(0, 8'h00); op(1, 8'h13); op(0, 8'h00); op(2, 8'h20); op(2, 8'h03);
        op(4, 8'h20); op(0, 8'h00); op(4, 8'hE3); op(0, 8'h00); op(4, 8'h80); op(4, 8'h00);
        cur_a0 = 1'b0; cur_irr = 8'h0F; cur_isr = 8'h80;
        op(5, 8'h0B); op(5, 8'h0A); op(5, 8'h68); op(5, 8'h0C); op(0, 8'h00);
        op(2, 8'h1F); op(1, 8'h13); op(2, 8'h20);
        cyc(1, 1, 0, 0, 0, 0, 8'h13);
        op(1, 8'h13); op(2, 8'h20); op(2, 8'h1F); op(1, 8'h13); op(2, 8'h20); op(1, 8'h12);
        op(0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            if ($urandom_range(0, 15) == 0) begin
                cur_irr = 8'($urandom); cur_isr = 8'($urandom);
            end
            cur_a0 = $urandom_range(0, 1) == 1;
            cyc(k == 0, k >= 1 && k <= 3, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0, 8'($urandom));
        end
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout pending=%0d", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
